// File: rtl/beat_meter_pkg.sv
// beat_meter_pkg: measurement state encoding and default sizing shared by the
// beat period meter and its testbench.
package beat_meter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      MEAS  = 2'd2
   } meter_state_t;

   localparam int          DEFAULT_CW      = 32;
   localparam int unsigned DEFAULT_TIMEOUT = 32'd50000000;

endpackage

// File: rtl/sync_rise_det.sv
// sync_rise_det: brings an asynchronous level into the clkin domain through a
// SYNC_STAGES-deep flop chain (minimum 2), keeps one history flop and emits a
// registered one-cycle pulse on every synchronized rising edge.
// dout is the history flop, so it is high during the cycle rise is high and
// tracks the same sample that produced the pulse.
module sync_rise_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clkin,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   rise_q;

   // Synchronizer chain, edge history and registered rising-edge pulse.
   always_ff @(posedge clkin) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         hist_q <= sync_q[SYNC_STAGES-1];
         rise_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
      end
   end

   assign dout = hist_q;
   assign rise = rise_q;

endmodule

// File: rtl/beat_period_meter.sv
// beat_period_meter: measures the period of a slow asynchronous beat signal in
// clkin cycles, strobes period_valid once per measured period, reports lock
// and raises a sticky timeout when no edge arrives within TIMEOUT cycles.
// Optional build macro BEAT_PERIOD_METER_DUTY_EN adds a hightime output that
// reports how many cycles the signal was high in the completed period.
module beat_period_meter
   import beat_meter_pkg::*;
#(
   parameter int          CW          = DEFAULT_CW,
   parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT,
   parameter int          SYNC_STAGES = 2
) (
   input  logic          clkin,
   input  logic          rst,
   input  logic          sigin,
   output logic [CW-1:0] period,
   output logic          period_valid,
`ifdef BEAT_PERIOD_METER_DUTY_EN
   output logic [CW-1:0] hightime,
`endif
   output logic          locked,
   output logic          timeout
);

   localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);
   localparam logic [CW-1:0] ONE         = CW'(1);

   meter_state_t  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] period_q, period_d;
   logic          valid_q, valid_d;
   logic          locked_q, locked_d;
   logic          timeout_q, timeout_d;
   logic          rise;
`ifdef BEAT_PERIOD_METER_DUTY_EN
   logic          level;
   logic [CW-1:0] hcnt_q, hcnt_d;
   logic [CW-1:0] hightime_q, hightime_d;
`else
   logic          level_unused;
`endif

   sync_rise_det #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clkin(clkin),
      .rst  (rst),
      .din  (sigin),
`ifdef BEAT_PERIOD_METER_DUTY_EN
      .dout (level),
`else
      .dout (level_unused),
`endif
      .rise (rise)
   );

   // Next-state logic: a rise always beats the timeout, and the counter is
   // bounded by TIMEOUT so it can never wrap.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      valid_d   = 1'b0;
      locked_d  = locked_q;
      timeout_d = timeout_q;
`ifdef BEAT_PERIOD_METER_DUTY_EN
      hcnt_d     = hcnt_q;
      hightime_d = hightime_q;
`endif
      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d   = ARMED;
               cnt_d     = ONE;
               timeout_d = 1'b0;
`ifdef BEAT_PERIOD_METER_DUTY_EN
               hcnt_d    = ONE;
`endif
            end
         end
         ARMED, MEAS: begin
            if (rise) begin
               state_d   = MEAS;
               period_d  = cnt_q;
               valid_d   = 1'b1;
               locked_d  = 1'b1;
               timeout_d = 1'b0;
               cnt_d     = ONE;
`ifdef BEAT_PERIOD_METER_DUTY_EN
               hightime_d = hcnt_q;
               hcnt_d     = ONE;
`endif
            end else if (cnt_q == TIMEOUT_CNT) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
               locked_d  = 1'b0;
               cnt_d     = '0;
`ifdef BEAT_PERIOD_METER_DUTY_EN
               hcnt_d    = '0;
`endif
            end else begin
               cnt_d = cnt_q + ONE;
`ifdef BEAT_PERIOD_METER_DUTY_EN
               hcnt_d = hcnt_q + CW'(level);
`endif
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and measurement registers with synchronous reset.
   always_ff @(posedge clkin) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         period_q  <= '0;
         valid_q   <= 1'b0;
         locked_q  <= 1'b0;
         timeout_q <= 1'b0;
`ifdef BEAT_PERIOD_METER_DUTY_EN
         hcnt_q     <= '0;
         hightime_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         valid_q   <= valid_d;
         locked_q  <= locked_d;
         timeout_q <= timeout_d;
`ifdef BEAT_PERIOD_METER_DUTY_EN
         hcnt_q     <= hcnt_d;
         hightime_q <= hightime_d;
`endif
      end
   end

   assign period       = period_q;
   assign period_valid = valid_q;
   assign locked       = locked_q;
   assign timeout      = timeout_q;
`ifdef BEAT_PERIOD_METER_DUTY_EN
   assign hightime     = hightime_q;
`endif

endmodule
